// File: rtl/rtb_pkg.sv
// rtb_pkg: rotation mode/direction encodings and quarter-turn reduction
package rtb_pkg;
  typedef enum logic [1:0] {ROT_0 = 2'd0, ROT_90 = 2'd1, ROT_180 = 2'd2, ROT_270 = 2'd3} rot_mode_e;
  typedef enum logic {DIR_CW = 1'b0, DIR_CCW = 1'b1} rot_dir_e;
  function automatic logic [1:0] rtb_k(input logic dir, input logic [1:0] mode);
    return dir == DIR_CCW ? 2'(2'd0 - mode) : mode;
  endfunction
endpackage

// File: rtl/rtb_addr_map.sv
// rtb_addr_map: output raster index to source index for k clockwise quarter-turns
module rtb_addr_map import rtb_pkg::*; #(
  parameter int TILE = 4,
  localparam int LW = $clog2(TILE),
  localparam int IW = 2 * LW
) (
  input  logic [IW-1:0] i_idx,
  input  logic [1:0]    i_k,
  output logic [IW-1:0] o_src
);
  logic [LW-1:0] r, c;
  // N-1-x is the bitwise complement because N is a power of two
  always_comb begin
    r = i_idx[IW-1:LW];
    c = i_idx[LW-1:0];
    o_src = i_k == ROT_0 ? i_idx : i_k == ROT_90 ? {~c, r} : i_k == ROT_180 ? {~r, ~c} : {c, ~r};
  end
endmodule

// File: rtl/rot_tile_buffer.sv
// rot_tile_buffer: ping-pong square tile buffer with streamed rotated readout
module rot_tile_buffer import rtb_pkg::*; #(
  parameter int PIX_W = 24,
  parameter int TILE  = 4,
  parameter int CNT_W = 16
) (
  input  logic             I_RTB_HCLK,
  input  logic             I_RTB_RESET,
  input  logic [1:0]       I_RTB_MODE,
  input  logic             I_RTB_DIR,
  input  logic             I_RTB_IN_VALID,
  output logic             O_RTB_IN_READY,
  input  logic [PIX_W-1:0] I_RTB_IN_PIXEL,
  output logic             O_RTB_OUT_VALID,
  input  logic             I_RTB_OUT_READY,
  output logic [PIX_W-1:0] O_RTB_OUT_PIXEL,
  output logic             O_RTB_OUT_LAST,
  output logic             O_RTB_TILE_DONE,
  output logic [CNT_W-1:0] O_RTB_TILE_CNT,
  output logic             O_RTB_BUSY
);
  localparam int LW = $clog2(TILE);
  localparam int IW = 2 * LW;
  localparam logic [IW-1:0] LAST_IDX = '1;
  logic             wbank_q, wbank_d, rbank_q, rbank_d;
  logic [IW-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d, src;
  logic [1:0]       full_q, full_d;
  logic [2:0]       mode_q [2];
  logic [2:0]       mode_d [2];
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] mem_q [2][TILE*TILE];
  logic             in_fire, out_fire, out_last, wr_end, rd_end, mode_ld;
  logic [1:0]       k;
  // handshakes, bank bookkeeping and latched per-bank rotation
  always_comb begin
    in_fire = I_RTB_IN_VALID & ~full_q[wbank_q];
    out_fire = full_q[rbank_q] & I_RTB_OUT_READY;
    out_last = full_q[rbank_q] & (rcnt_q == LAST_IDX);
    wr_end = in_fire & (wcnt_q == LAST_IDX);
    rd_end = out_fire & out_last;
    wcnt_d = in_fire ? wcnt_q + IW'(1) : wcnt_q;
    rcnt_d = out_fire ? rcnt_q + IW'(1) : rcnt_q;
    wbank_d = wbank_q ^ wr_end;
    rbank_d = rbank_q ^ rd_end;
    full_d = (full_q & ~(2'(rd_end) << rbank_q)) | (2'(wr_end) << wbank_q);
    mode_ld = in_fire & (wcnt_q == '0);
    mode_d[0] = mode_ld & ~wbank_q ? {I_RTB_DIR, I_RTB_MODE} : mode_q[0];
    mode_d[1] = mode_ld & wbank_q ? {I_RTB_DIR, I_RTB_MODE} : mode_q[1];
    done_d = rd_end;
    cnt_d = cnt_q + CNT_W'(rd_end);
    k = rtb_k(mode_q[rbank_q][2], mode_q[rbank_q][1:0]);
  end
  // control state register
  always_ff @(posedge I_RTB_HCLK) begin
    if (I_RTB_RESET) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      full_q <= '0;
      mode_q[0] <= '0;
      mode_q[1] <= '0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      full_q <= full_d;
      mode_q[0] <= mode_d[0];
      mode_q[1] <= mode_d[1];
      done_q <= done_d;
      cnt_q <= cnt_d;
    end
  end
  // pixel storage is written in input raster order and never reset
  always_ff @(posedge I_RTB_HCLK) begin
    if (in_fire) mem_q[wbank_q][wcnt_q] <= I_RTB_IN_PIXEL;
  end
  rtb_addr_map #(.TILE(TILE)) u_addr_map (
    .i_idx (rcnt_q),
    .i_k   (k),
    .o_src (src)
  );
  assign O_RTB_IN_READY  = ~full_q[wbank_q];
  assign O_RTB_OUT_VALID = full_q[rbank_q];
  assign O_RTB_OUT_PIXEL = mem_q[rbank_q][src];
  assign O_RTB_OUT_LAST  = out_last;
  assign O_RTB_TILE_DONE = done_q;
  assign O_RTB_TILE_CNT  = cnt_q;
  assign O_RTB_BUSY      = (|full_q) | (wcnt_q != '0);
endmodule

// File: tb/tb_rot_tile_buffer.sv
// tb_rot_tile_buffer: random and directed checks against a tile-rotation model
module tb_rot_tile_buffer;
  localparam int N = 4;
  localparam int NN = N * N;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mode = '0;
  logic dir = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [23:0] in_pix = '0;
  logic in_ready, out_valid, out_last, tile_done, busy;
  logic [23:0] out_pix;
  logic [15:0] tile_cnt;
  int errors = 0, checks = 0, done_pulses = 0;
  bit started = 0;
  logic [23:0] cap[$];
  logic [23:0] wbuf[NN];
  logic [23:0] exp_q[$];
  int wn = 0, ntiles = 0, rn = 0, mk = 0;
  logic m_done = 1'b0, m_in_fire = 1'b0;
  logic [15:0] m_cnt = '0;

  rot_tile_buffer #(.PIX_W(24), .TILE(N), .CNT_W(16)) dut (
    .I_RTB_HCLK      (clk),
    .I_RTB_RESET     (rst),
    .I_RTB_MODE      (mode),
    .I_RTB_DIR       (dir),
    .I_RTB_IN_VALID  (in_valid),
    .O_RTB_IN_READY  (in_ready),
    .I_RTB_IN_PIXEL  (in_pix),
    .O_RTB_OUT_VALID (out_valid),
    .I_RTB_OUT_READY (out_ready),
    .O_RTB_OUT_PIXEL (out_pix),
    .O_RTB_OUT_LAST  (out_last),
    .O_RTB_TILE_DONE (tile_done),
    .O_RTB_TILE_CNT  (tile_cnt),
    .O_RTB_BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // pixel of the rotated tile at (r,c): apply k single clockwise quarter-turns
  function automatic logic [23:0] rot_px(input int k, input int r, input int c);
    int rr = r, cc = c, t;
    repeat (k) begin
      t = rr;
      rr = N - 1 - cc;
      cc = t;
    end
    return wbuf[rr * N + cc];
  endfunction

  task automatic model_step();
    bit inf, outf;
    inf = in_valid && ntiles < 2;
    outf = ntiles > 0 && out_ready;
    m_in_fire = !rst && inf;
    if (rst) begin
      wn = 0; ntiles = 0; rn = 0; m_done = 0; m_cnt = '0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (outf) begin
        void'(exp_q.pop_front());
        rn++;
        if (rn == NN) begin
          rn = 0; ntiles--; m_done = 1; m_cnt++;
        end
      end
      if (inf) begin
        if (wn == 0) mk = dir ? (4 - int'(mode)) % 4 : int'(mode);
        wbuf[wn] = in_pix;
        wn++;
        if (wn == NN) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) exp_q.push_back(rot_px(mk, r, c));
          ntiles++;
          wn = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("in_ready", in_ready, ntiles < 2);
      chk("out_valid", out_valid, ntiles > 0);
      chk("busy", busy, ntiles > 0 || wn != 0);
      chk("tile_done", tile_done, m_done);
      chk("tile_cnt", tile_cnt, m_cnt);
      if (ntiles > 0) begin
        chk("out_pixel", out_pix, exp_q[0]);
        chk("out_last", out_last, rn == NN - 1);
      end
      if (tile_done === 1'b1) done_pulses++;
      if (out_valid && out_ready && !rst) cap.push_back(out_pix);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [23:0] p, input logic [1:0] m, input logic d);
    int t = 0;
    mode = m; dir = d; in_pix = p; in_valid = 1'b1;
    do begin
      step();
      t++;
    end while (!m_in_fire && t < 300);
    if (!m_in_fire) chk("in_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input int base, input int m0, input int m1, input int sw, input logic d);
    for (int i = 0; i < NN; i++) send_px(24'(base + i), 2'(i < sw ? m0 : m1), d);
  endtask

  task automatic wait_cap(input int n);
    int t = 0;
    while (cap.size() < n && t < 400) begin
      step();
      t++;
    end
    chk("out_count_reached", cap.size() >= n, 1);
  endtask

  task automatic expect_tile(input string name, input int off, input int e[16]);
    for (int i = 0; i < NN; i++) chk(name, cap[off + i], e[i]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int asc[16], desc[16], rot90[16], rot270[16];
    int d0;
    for (int i = 0; i < NN; i++) begin
      asc[i] = i;
      desc[i] = NN - 1 - i;
    end
    rot90 = '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3};
    rot270 = '{3, 7, 11, 15, 2, 6, 10, 14, 1, 5, 9, 13, 0, 4, 8, 12};
    @(posedge clk);
    started = 1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tile_cnt", tile_cnt, 0);
    step();
    out_ready = 1'b1;
    cap.delete();
    d0 = done_pulses;
    send_tile(0, 0, 0, 16, 1'b0);
    wait_cap(16);
    repeat (3) step();
    expect_tile("s1_rot0", 0, asc);
    chk("s1_done_pulses", done_pulses - d0, 1);
    chk("s1_tile_cnt", tile_cnt, 1);
    cap.delete();
    send_tile(0, 1, 1, 16, 1'b0);
    wait_cap(16);
    expect_tile("s2_cw90", 0, rot90);
    cap.delete();
    send_tile(0, 1, 1, 16, 1'b1);
    send_tile(0, 3, 3, 16, 1'b0);
    wait_cap(32);
    expect_tile("s3_ccw90", 0, rot270);
    expect_tile("s3_cw270", 16, rot270);
    cap.delete();
    send_tile(0, 2, 2, 16, 1'b0);
    send_tile(0, 2, 1, 5, 1'b0);
    wait_cap(32);
    expect_tile("s4_rot180", 0, desc);
    expect_tile("s4_midtile_mode", 16, desc);
    repeat (3) step();
    pulse_reset();
    out_ready = 1'b0;
    cap.delete();
    send_tile(0, 0, 0, 16, 1'b0);
    send_tile(16, 0, 0, 16, 1'b0);
    in_valid = 1'b1; in_pix = 24'd32; mode = 2'd0;
    repeat (5) step();
    @(negedge clk);
    chk("s5_full_in_ready", in_ready, 0);
    chk("s5_full_busy", busy, 1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    send_tile(32, 0, 0, 16, 1'b0);
    wait_cap(48);
    repeat (3) step();
    for (int i = 0; i < 48; i++) chk("s5_order", cap[i], i);
    chk("s5_tile_cnt", tile_cnt, 3);
    pulse_reset();
    out_ready = 1'b0;
    send_tile(0, 0, 0, 16, 1'b0);
    for (int i = 0; i < 7; i++) send_px(24'(16 + i), 2'd0, 1'b0);
    pulse_reset();
    @(negedge clk);
    chk("s6_out_valid", out_valid, 0);
    chk("s6_in_ready", in_ready, 1);
    chk("s6_tile_cnt", tile_cnt, 0);
    chk("s6_busy", busy, 0);
    step();
    out_ready = 1'b1;
    cap.delete();
    send_tile(100, 0, 0, 16, 1'b0);
    wait_cap(16);
    for (int i = 0; i < NN; i++) chk("s6_fresh_tile", cap[i], 100 + i);
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_pix = 24'($urandom);
      mode = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (80) step();
    chk("drain_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rot_tile_buffer.md
Name: rot_tile_buffer

Overview:
- Parametrised ping-pong tile buffer that rotates square pixel tiles by 0/90/180/270 degrees, clockwise or counter-clockwise.
- Sits between the DMA read path and the DMA write path of the rotation engine.
- Replaces the fixed per-byte pixel address outputs of the current core with a streamed, tile-based datapath.
- Generalises pixel width and tile size, and adds double buffering and valid/ready backpressure.

Parameters:
PIX_W, 24, pixel width in bits (24 = RGB888).
TILE, 4, tile edge length N in pixels; power of 2, 2..16; tile holds N*N pixels.
CNT_W, 16, width of completed-tile counter.

Ports:
I_RTB_HCLK  in  1  clock
I_RTB_RESET  in  1  reset, synchronous, active-high
I_RTB_MODE  in  2  0=0deg, 1=90deg, 2=180deg, 3=270deg
I_RTB_DIR  in  1  0=clockwise, 1=counter-clockwise
I_RTB_IN_VALID  in  1  input pixel valid
O_RTB_IN_READY  out  1  buffer can accept pixel
I_RTB_IN_PIXEL  in  PIX_W  input pixel, tile row-major order
O_RTB_OUT_VALID  out  1  output pixel valid
I_RTB_OUT_READY  in  1  downstream accepts pixel
O_RTB_OUT_PIXEL  out  PIX_W  rotated pixel, output row-major order
O_RTB_OUT_LAST  out  1  last pixel of output tile
O_RTB_TILE_DONE  out  1  one-cycle pulse per completed output tile
O_RTB_TILE_CNT  out  CNT_W  completed output tiles, wraps at 2^CNT_W
O_RTB_BUSY  out  1  any bank full or write in progress

Behaviour:
Clock and reset:
- One clock, I_RTB_HCLK.
- I_RTB_RESET is synchronous, active-high.

Reset values:
- wbank=0, rbank=0, wcnt=0, rcnt=0, full[1:0]=0.
- O_RTB_OUT_VALID=0, O_RTB_TILE_DONE=0, O_RTB_TILE_CNT=0, O_RTB_BUSY=0, O_RTB_IN_READY=1.
- Pixel storage is not reset.

Storage:
- Two banks of N*N x PIX_W registers.

Write side:
- O_RTB_IN_READY = !full[wbank].
- Input handshake (valid & ready) stores the pixel at mem[wbank][wcnt], then wcnt++.
- On wcnt==0 handshake, latch mode_b[wbank] = {I_RTB_DIR, I_RTB_MODE}. Mode changes mid-tile are ignored.
- On wcnt==N*N-1 handshake: full[wbank]<=1, wcnt<=0, wbank toggles.

Read side:
- O_RTB_OUT_VALID = full[rbank].
- First output is valid the cycle after the last input write. Throughput is 1 pixel/cycle sustained on both sides.
- Output index rcnt = r*N + c. Effective clockwise quarter-turns k = DIR ? (4-MODE) mod 4 : MODE. Source pixel:
  - k=0: in(r,c)
  - k=1: in(N-1-c, r)
  - k=2: in(N-1-r, N-1-c)
  - k=3: in(c, N-1-r)
- O_RTB_OUT_PIXEL is a combinational read of mem[rbank][src].
- O_RTB_OUT_LAST = valid & (rcnt==N*N-1).
- Output handshake: rcnt++.
- Handshake with LAST: full[rbank]<=0, rcnt<=0, rbank toggles, TILE_DONE<=1 next cycle, TILE_CNT++ (wraps).

Boundaries:
- Both banks full: IN_READY=0 until the reader frees a bank. READY rises the cycle after the freeing handshake.
- A write completing one bank and a read completing the other bank in the same cycle are both honoured.
- Same-bank set/clear cannot coincide.
- OUT_READY low holds OUT_PIXEL, OUT_VALID and OUT_LAST stable.
- Reset mid-tile discards partial and full tiles; no output follows reset until a complete new tile has been written.

BUSY:
- O_RTB_BUSY = |full | (wcnt!=0).

Decomposition:
- rtb_pkg: mode encodings (ROT_0/90/180/270), direction encodings, and the k-reduction function.
- Sub-module rtb_addr_map: combinational (rcnt, k, N) -> source index. Reused by the future DMA address generator.

Test Plan:
All scenarios use PIX_W=24, TILE=4, input pixels 0..15.
1. MODE=0, DIR=0, OUT_READY=1 -> output 0..15, LAST with 15, TILE_DONE pulses once, TILE_CNT=1.
2. MODE=1, DIR=0 -> output 12,8,4,0,13,9,5,1,14,10,6,2,15,11,7,3.
3. MODE=1, DIR=1 -> output 3,7,11,15,2,6,10,14,1,5,9,13,0,4,8,12. MODE=3, DIR=0 -> identical stream.
4. MODE=2 -> output 15..0. Mode switched to 1 at pixel 5 of the next tile -> that tile still outputs 15..0.
5. OUT_READY=0, stream 3 tiles -> 32 pixels accepted, then IN_READY=0. Release -> tile A then tile B output back-to-back. IN_READY=1 the cycle after tile A's LAST handshake. TILE_CNT reaches 3.
6. One full tile plus 7 pixels written, then RESET pulsed 1 cycle -> OUT_VALID=0, IN_READY=1, TILE_CNT=0, BUSY=0. A new tile (MODE=0) outputs 0..15 with no stale pixels.
